// File: rtl/memwb_skid_stage_if.sv
// Handshake and payload bundle between the memory stage, the MEM/WB skid stage and writeback.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface memwb_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_wr;
  logic [ADDR_W-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_wr;
  logic [ADDR_W-1:0] out_rd;

  modport slave (
    input  in_valid, in_data, in_wr, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_wr, out_rd
  );

  modport master (
    output in_valid, in_data, in_wr, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_wr, out_rd
  );
endinterface

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage with a 2-entry skid buffer (head H, skid S), flush and write-enable gating.
// Define MEMWB_FWD_EN to add the combinational forwarding lookup ports (fwd_addr/fwd_hit/fwd_data).
module memwb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
`ifdef MEMWB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  memwb_skid_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] h_data_q, h_data_d;
  logic              h_wr_q, h_wr_d;
  logic [ADDR_W-1:0] h_rd_q, h_rd_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              s_wr_q, s_wr_d;
  logic [ADDR_W-1:0] s_rd_q, s_rd_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_wr_q, out_wr_d;

  logic accept;
  logic consume;

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = out_valid_q & bus.out_ready;

  always_comb begin
    state_d  = state_q;
    h_data_d = h_data_q;
    h_wr_d   = h_wr_q;
    h_rd_d   = h_rd_q;
    s_data_d = s_data_q;
    s_wr_d   = s_wr_q;
    s_rd_d   = s_rd_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          h_data_d = bus.in_data;
          h_wr_d   = bus.in_wr;
          h_rd_d   = bus.in_rd;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          h_data_d = bus.in_data;
          h_wr_d   = bus.in_wr;
          h_rd_d   = bus.in_rd;
        end else if (accept) begin
          s_data_d = bus.in_data;
          s_wr_d   = bus.in_wr;
          s_rd_d   = bus.in_rd;
          state_d  = TWO;
        end else if (consume) begin
          state_d  = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          h_data_d = s_data_q;
          h_wr_d   = s_wr_q;
          h_rd_d   = s_rd_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops every beat, including one arriving this cycle; payload registers keep their contents.
    if (flush) begin
      state_d  = EMPTY;
      h_data_d = h_data_q;
      h_wr_d   = h_wr_q;
      h_rd_d   = h_rd_q;
      s_data_d = s_data_q;
      s_wr_d   = s_wr_q;
      s_rd_d   = s_rd_q;
    end

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
    out_wr_d    = h_wr_d & out_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      h_data_q    <= '0;
      h_wr_q      <= 1'b0;
      h_rd_q      <= '0;
      s_data_q    <= '0;
      s_wr_q      <= 1'b0;
      s_rd_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_data_q    <= h_data_d;
      h_wr_q      <= h_wr_d;
      h_rd_q      <= h_rd_d;
      s_data_q    <= s_data_d;
      s_wr_q      <= s_wr_d;
      s_rd_q      <= s_rd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_wr_q    <= out_wr_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_wr    = out_wr_q;
  assign bus.out_data  = h_data_q;
  assign bus.out_rd    = h_rd_q;

`ifdef MEMWB_FWD_EN
  // S is younger than H, so it wins when both match; register 0 is never forwarded.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if ((state_q == TWO) && s_wr_q && (s_rd_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = s_data_q;
      end else if ((state_q != EMPTY) && h_wr_q && (h_rd_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = h_data_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Self-checking bench for memwb_skid_stage: directed scenarios plus randomized traffic, checked
// against a queue-based model of the stage contents and a scoreboard drained by a separate monitor.
module tb_memwb_skid_stage;

  typedef struct {
    logic [31:0] data;
    logic        wr;
    logic [4:0]  rd;
  } beat_t;

  logic clk;
  logic rst;
  logic flush;
`ifdef MEMWB_FWD_EN
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  memwb_skid_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  memwb_skid_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
`ifdef MEMWB_FWD_EN
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
`endif
    .bus      (bus)
  );

  int    tests_run = 0;
  int    fail_count = 0;
  beat_t model_q[$];
  beat_t exp_q[$];
  beat_t last_head;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the visible stage outputs against the model of what the stage currently holds.
  task automatic checkState();
    beat_t head;
    int    n;
    n = model_q.size();
    head = (n > 0) ? model_q[0] : last_head;
    checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, (n < 2)});
    checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, (n > 0)});
    checkOutput("out_wr", {31'd0, bus.out_wr}, {31'd0, ((n > 0) && head.wr)});
    checkOutput("out_data", bus.out_data, head.data);
    checkOutput("out_rd", {27'd0, bus.out_rd}, {27'd0, head.rd});
  endtask

`ifdef MEMWB_FWD_EN
  task automatic fwdCheck(input logic [4:0] addr);
    logic        hit;
    logic [31:0] data;
    hit  = 1'b0;
    data = 32'd0;
    if (addr != 5'd0) begin
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (!hit && model_q[i].wr && (model_q[i].rd == addr)) begin
          hit  = 1'b1;
          data = model_q[i].data;
        end
      end
    end
    fwd_addr = addr;
    #1;
    checkOutput("fwd_hit", {31'd0, fwd_hit}, {31'd0, hit});
    checkOutput("fwd_data", fwd_data, data);
  endtask
`endif

  // One cycle: check outputs, drive inputs for the coming edge, and advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic w,
                               input logic [4:0] r, input logic ordy, input logic fl);
    beat_t b;
    bit    acc;
    bit    cons;
    @(negedge clk);
`ifdef MEMWB_FWD_EN
    fwdCheck(5'($urandom_range(0, 7)));
`endif
    checkState();
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_wr     = w;
    bus.in_rd     = r;
    bus.out_ready = ordy;
    flush         = fl;
    acc  = v && (model_q.size() < 2);
    cons = ordy && (model_q.size() > 0);
    if (fl) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      if (cons) void'(model_q.pop_front());
      if (acc) begin
        b.data = d;
        b.wr   = w;
        b.rd   = r;
        model_q.push_back(b);
        exp_q.push_back(b);
      end
      if (model_q.size() > 0) last_head = model_q[0];
    end
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, ordy, 1'b0);
  endtask

  // Monitor: every delivered beat must match the oldest outstanding scoreboard entry.
  always begin
    beat_t e;
    @(negedge clk);
    #2;
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_beat", bus.out_data, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_data", bus.out_data, e.data);
        checkOutput("sb_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
        checkOutput("sb_wr", {31'd0, bus.out_wr}, {31'd0, e.wr});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_wr     = 1'b0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b0;
`ifdef MEMWB_FWD_EN
    fwd_addr      = 5'd0;
`endif
    last_head     = '{data: 32'd0, wr: 1'b0, rd: 5'd0};
    #1;
    checkState();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Streaming with downstream always ready.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'(i + 1) * 32'h11, 1'b1, 5'(i + 1), 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Backpressure: A1, A2 absorbed, A3 held upstream until space frees.
    applyStimulus(1'b1, 32'hA1, 1'b1, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA2, 1'b1, 5'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA3, 1'b1, 5'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA3, 1'b1, 5'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hA3, 1'b1, 5'd3, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Flush from TWO with downstream ready.
    applyStimulus(1'b1, 32'hB1, 1'b1, 5'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB2, 1'b1, 5'd6, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    repeat (3) idle(1'b1);

    // Non-writing beat: out_wr stays low, data held once empty.
    applyStimulus(1'b1, 32'h77, 1'b0, 5'd7, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Fill H and S with writes to r5, then probe the forwarding lookup.
    applyStimulus(1'b1, 32'h100, 1'b1, 5'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(1'b0);
`ifdef MEMWB_FWD_EN
    @(negedge clk);
    fwdCheck(5'd5);
    checkOutput("fwd_s_wins", fwd_data, 32'h200);
    fwdCheck(5'd0);
`endif

    // Asynchronous reset in the middle of a cycle while holding two beats.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    exp_q.delete();
    last_head = '{data: 32'd0, wr: 1'b0, rd: 5'd0};
    checkState();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h5A, 1'b1, 5'd9, 1'b0, 1'b0);
    repeat (2) idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 99) < 3));

    for (int i = 0; i < 10; i++)
      if (exp_q.size() != 0) idle(1'b1);
    idle(1'b1);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
